// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
// Rejected opcodes (4'b11xx) answer with err=1 and leave the ALU-side registers untouched.
module alu_arbiter #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [3:0]             op0,
  input  logic [3:0]             op1,
  input  logic [WORD_LENGTH-1:0] a0,
  input  logic [WORD_LENGTH-1:0] a1,
  input  logic [WORD_LENGTH-1:0] b0,
  input  logic [WORD_LENGTH-1:0] b1,
  input  logic [4:0]             shmt0,
  input  logic [4:0]             shmt1,
  output logic                   grant0,
  output logic                   grant1,
  output logic                   done0,
  output logic                   done1,
  output logic [WORD_LENGTH-1:0] result,
  output logic                   carry,
  output logic                   zero,
  output logic                   negative,
  output logic                   err,
  output logic [WORD_LENGTH-1:0] alu_dataA,
  output logic [WORD_LENGTH-1:0] alu_dataB,
  output logic [3:0]             alu_control,
  output logic [4:0]             alu_shmt,
  input  logic [WORD_LENGTH-1:0] alu_dataC,
  input  logic                   alu_carry,
  input  logic                   alu_zero,
  input  logic                   alu_negative
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic                   last_q, last_d;
  logic                   win_q, win_d;
  logic                   grant0_q, grant0_d;
  logic                   grant1_q, grant1_d;
  logic [3:0]             op_q, op_d;
  logic [WORD_LENGTH-1:0] a_q, a_d;
  logic [WORD_LENGTH-1:0] b_q, b_d;
  logic [4:0]             shmt_q, shmt_d;
  logic [WORD_LENGTH-1:0] result_q, result_d;
  logic                   carry_q, carry_d;
  logic                   zero_q, zero_d;
  logic                   negative_q, negative_d;
  logic                   err_q, err_d;

  logic                   sel;
  logic [3:0]             sel_op;
  logic [WORD_LENGTH-1:0] sel_a;
  logic [WORD_LENGTH-1:0] sel_b;
  logic [4:0]             sel_shmt;

  // On a tie the requester that was not served last wins.
  always_comb begin
    sel      = (req0 && req1) ? ~last_q : req1;
    sel_op   = sel ? op1   : op0;
    sel_a    = sel ? a1    : a0;
    sel_b    = sel ? b1    : b0;
    sel_shmt = sel ? shmt1 : shmt0;
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    grant0_d   = 1'b0;
    grant1_d   = 1'b0;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    shmt_d     = shmt_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win_d    = sel;
          grant0_d = ~sel;
          grant1_d = sel;
          if (sel_op[3:2] == 2'b11) begin
            result_d   = '0;
            carry_d    = 1'b0;
            zero_d     = 1'b0;
            negative_d = 1'b0;
            err_d      = 1'b1;
            state_d    = RESP;
          end else begin
            op_d    = sel_op;
            a_d     = sel_a;
            b_d     = sel_b;
            shmt_d  = sel_shmt;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        result_d   = alu_dataC;
        carry_d    = alu_carry;
        zero_d     = alu_zero;
        negative_d = alu_negative;
        err_d      = 1'b0;
        state_d    = RESP;
      end
      RESP: begin
        last_d  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      win_q      <= 1'b0;
      grant0_q   <= 1'b0;
      grant1_q   <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      shmt_q     <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      grant0_q   <= grant0_d;
      grant1_q   <= grant1_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      shmt_q     <= shmt_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      err_q      <= err_d;
    end
  end

  assign grant0      = grant0_q;
  assign grant1      = grant1_q;
  assign done0       = (state_q == RESP) && !win_q;
  assign done1       = (state_q == RESP) && win_q;
  assign result      = result_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign negative    = negative_q;
  assign err         = err_q;
  assign alu_dataA   = a_q;
  assign alu_dataB   = b_q;
  assign alu_control = op_q;
  assign alu_shmt    = shmt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a stub ALU
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [3:0]   op0 = '0, op1 = '0;
  logic [W-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [4:0]   shmt0 = '0, shmt1 = '0;
  logic         grant0, grant1, done0, done1;
  logic [W-1:0] result;
  logic         carry, zero, negative, err;
  logic [W-1:0] alu_dataA, alu_dataB, alu_dataC;
  logic [3:0]   alu_control;
  logic [4:0]   alu_shmt;
  logic         alu_carry, alu_zero, alu_negative;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int gcyc = 0;

  typedef struct {
    bit           id;
    logic [W-1:0] res;
    logic         c, z, n, e;
    logic [3:0]   aop;
    logic [W-1:0] aa, ab;
    logic [4:0]   ash;
    int           lat;
  } exp_t;

  bit   gq[$];
  exp_t rq[$];

  bit           last_m = 1'b1;
  logic [3:0]   mop = '0;
  logic [W-1:0] ma = '0, mb = '0;
  logic [4:0]   msh = '0;

  alu_arbiter #(.WORD_LENGTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .shmt0(shmt0), .shmt1(shmt1),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .result(result), .carry(carry), .zero(zero), .negative(negative), .err(err),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_control(alu_control), .alu_shmt(alu_shmt),
    .alu_dataC(alu_dataC), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_negative(alu_negative)
  );

  // Stub ALU: returns {carry, zero, negative, result}
  function automatic logic [W+2:0] alu_f(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [4:0] sh);
    logic [W:0]   wide;
    logic [W-1:0] r;
    logic         c, n;
    r = '0; c = 1'b0; wide = '0;
    case (op)
      4'h0: r = a & b;
      4'h1: r = (a >= b) ? a - b : b - a;
      4'h2: begin wide = {1'b0, a} + {1'b0, b}; r = wide[W-1:0]; c = wide[W]; end
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~(a | b);
      4'h6: begin wide = {1'b0, a} - {1'b0, b}; r = wide[W-1:0]; c = wide[W]; end
      4'h7: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'h8: r = b << sh;
      4'h9: r = b >> sh;
      4'hA: r = $signed(b) >>> sh;
      4'hB: r = (a << sh) | (a >> (W - int'(sh)));
      default: r = '0;
    endcase
    n = (op == 4'h1) ? (a < b) : r[W-1];
    return {c, (r == '0), n, r};
  endfunction

  assign {alu_carry, alu_zero, alu_negative, alu_dataC} = alu_f(alu_control, alu_dataA, alu_dataB, alu_shmt);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, expv, $time);
    else passes++;
  endtask

  task automatic push_op(input bit id, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh);
    exp_t e;
    gq.push_back(id);
    e.id = id;
    if (op >= 4'd12) begin
      e.res = '0; e.c = 0; e.z = 0; e.n = 0; e.e = 1; e.lat = 0;
    end else begin
      mop = op; ma = a; mb = b; msh = sh;
      {e.c, e.z, e.n, e.res} = alu_f(op, a, b, sh);
      e.e = 0; e.lat = 1;
    end
    e.aop = mop; e.aa = ma; e.ab = mb; e.ash = msh;
    rq.push_back(e);
    last_m = id;
  endtask

  task automatic scramble();
    if (!req0) begin op0 = 4'($urandom); a0 = $urandom; b0 = $urandom; shmt0 = 5'($urandom); end
    if (!req1) begin op1 = 4'($urandom); a1 = $urandom; b1 = $urandom; shmt1 = 5'($urandom); end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((req0 || req1) && n < budget) begin
      @(negedge clk); n++;
      if (done0) req0 = 1'b0;
      if (done1) req1 = 1'b0;
      scramble();
    end
    if (req0 || req1) begin
      checks++;
      $display("FAIL round_timeout: requests still pending after %0d cycles", budget);
      req0 = 1'b0; req1 = 1'b0;
    end
  endtask

  task automatic round(input bit r0, input bit r1, input logic [3:0] o0, input logic [3:0] o1,
                       input logic [W-1:0] xa0, input logic [W-1:0] xb0,
                       input logic [W-1:0] xa1, input logic [W-1:0] xb1,
                       input logic [4:0] s0, input logic [4:0] s1);
    bit first;
    @(negedge clk);
    req0 = r0; req1 = r1;
    op0 = o0; a0 = xa0; b0 = xb0; shmt0 = s0;
    op1 = o1; a1 = xa1; b1 = xb1; shmt1 = s1;
    first = (r0 && r1) ? !last_m : r1;
    if (first) push_op(1'b1, o1, xa1, xb1, s1);
    else       push_op(1'b0, o0, xa0, xb0, s0);
    if (r0 && r1) begin
      if (first) push_op(1'b0, o0, xa0, xb0, s0);
      else       push_op(1'b1, o1, xa1, xb1, s1);
    end
    wait_idle(30);
  endtask

  // Both requesters hold req through their done; exactly k operations are served.
  task automatic hold(input int k);
    bit nxt;
    int seen = 0, n = 0;
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    op0 = 4'h2; a0 = 32'd100; b0 = 32'd23; shmt0 = 5'd0;
    op1 = 4'h6; a1 = 32'd50;  b1 = 32'd8;  shmt1 = 5'd0;
    nxt = !last_m;
    for (int i = 0; i < k; i++) begin
      if (nxt) push_op(1'b1, op1, a1, b1, shmt1);
      else     push_op(1'b0, op0, a0, b0, shmt0);
      nxt = !nxt;
    end
    while (seen < k && n < 4 * k + 10) begin
      @(negedge clk); n++;
      if (done0 || done1) seen++;
    end
    if (seen < k) begin
      checks++;
      $display("FAIL hold_timeout: saw %0d of %0d dones", seen, k);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_grant"}, {grant0, grant1}, 0);
    chk({tag, "_done"}, {done0, done1}, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_flags"}, {carry, zero, negative, err}, 0);
    chk({tag, "_alu_ab"}, {alu_dataA, alu_dataB}, 0);
    chk({tag, "_alu_ctl"}, {alu_control, alu_shmt}, 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (grant0 || grant1) begin
        chk("grant_onehot", grant0 & grant1, 0);
        if (gq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_grant: grant0=%0b grant1=%0b with no request outstanding", grant0, grant1);
        end else begin
          chk("grant_id", grant1, gq.pop_front());
          gcyc = cyc;
        end
      end
      if (done0 || done1) begin
        chk("done_onehot", done0 & done1, 0);
        if (rq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: done0=%0b done1=%0b with no response expected", done0, done1);
        end else begin
          exp_t e;
          e = rq.pop_front();
          chk("done_id", done1, e.id);
          chk("result", result, e.res);
          chk("flags_czne", {carry, zero, negative, err}, {e.c, e.z, e.n, e.e});
          chk("alu_operands", {alu_control, alu_dataA, alu_dataB, alu_shmt}, {e.aop, e.aa, e.ab, e.ash});
          chk("latency", cyc - gcyc, e.lat);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 chk_zero_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    round(1, 1, 4'h2, 4'h1, 32'd5, 32'd7, 32'd3, 32'd9, 5'd0, 5'd0);
    chk("tie_result", result, 6);
    chk("tie_negative", negative, 1);

    round(1, 0, 4'h2, 4'h0, 32'd5, 32'd7, $urandom, $urandom, 5'd0, 5'd3);
    chk("add_result", result, 12);
    chk("add_zero_err", {zero, err}, 0);

    round(0, 1, 4'h0, 4'hE, $urandom, $urandom, $urandom, $urandom, 5'd1, 5'd9);
    chk("reject_err", err, 1);
    chk("reject_result", result, 0);
    chk("reject_alu_hold", {alu_control, alu_dataA, alu_dataB}, {4'h2, 32'd5, 32'd7});

    round(1, 0, 4'h1, 4'h3, 32'h55, 32'h55, $urandom, $urandom, 5'd0, 5'd0);
    chk("sub_eq_zero", zero, 1);
    chk("sub_eq_result_neg", {result, negative}, 0);

    round(1, 0, 4'h8, 4'h2, $urandom, 32'd1, $urandom, $urandom, 5'd4, 5'd0);
    chk("shift_result", result, 16);

    @(negedge clk);
    req0 = 1'b1; op0 = 4'h8; a0 = $urandom; b0 = 32'd1; shmt0 = 5'd4;
    gq.push_back(1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_zero_outputs("abort");
    req0 = 1'b0;
    mop = '0; ma = '0; mb = '0; msh = '0; last_m = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_result_held", {result, err}, 0);

    round(1, 1, 4'h3, 4'h9, 32'hF0, 32'h0F, $urandom, 32'h8000_0000, 5'd0, 5'd31);

    hold(8);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      int r;
      logic [W-1:0] x0, x1;
      r = $urandom_range(1, 3);
      x0 = $urandom; x1 = $urandom;
      round(r[0], r[1], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            x0, ($urandom_range(0, 3) == 0) ? x0 : $urandom,
            x1, ($urandom_range(0, 3) == 0) ? x1 : $urandom,
            5'($urandom), 5'($urandom));
    end

    repeat (4) @(negedge clk);
    chk("grant_queue_drained", gq.size(), 0);
    chk("resp_queue_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
